ce_pulse_gen: RTL and testbench

- Programmable clock-enable generator that sits directly upstream of the modulo-N counter.
- Its `ce_out` drives the counter's `ce` input.
- Produces single-cycle enable pulses at a programmable period in three modes:
  - continuous run,
  - counted burst,
  - single-step on request.
- Lets the counter be advanced freely, a fixed number of times, or one count at a time from a button/host interface.

---
 rtl/ce_gen_pkg.sv | 18 +
 rtl/ce_pulse_gen_rise_detect.sv | 41 ++++
 rtl/ce_pulse_gen.sv | 143 ++++++++++++++
 tb/tb_ce_pulse_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg
// Shared definitions for the clock-enable pulse generator:
//   - state_e     : FSM state encoding (IDLE=0, RUN=1, BURST=2, STEP=3)
//   - DIV_W_DEF   : default prescaler / period width
//   - BURST_W_DEF : default burst length / remaining-pulse counter width
package ce_gen_pkg;

  localparam int DIV_W_DEF   = 8;
  localparam int BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BURST = 2'd2,
    ST_STEP  = 2'd3
  } state_e;

endpackage

// File: rtl/ce_pulse_gen_rise_detect.sv
// rise_detect
// Registered rising-edge detector for a level request input.
// Ports:
//   clk    in  : clock
//   rst    in  : asynchronous active-low reset
//   in_sig in  : request level
//   pulse  out : one-cycle pulse, registered, one clock after the rise is seen
// An input that is already high when reset releases is not reported: the
// armed flag holds off detection for the first clock so in_q can catch up.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic in_sig,
  output logic pulse
);

  logic armed_q, armed_d;
  logic in_q,    in_d;
  logic pulse_q, pulse_d;

  always_comb begin
    armed_d = 1'b1;
    in_d    = in_sig;
    pulse_d = armed_q & in_sig & ~in_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed_q <= 1'b0;
      in_q    <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      in_q    <= in_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/ce_pulse_gen.sv
// ce_pulse_gen
// Programmable clock-enable generator feeding a downstream counter's ce.
// Modes: continuous run, counted burst, single step.
// Ports:
//   clk        in          : clock
//   rst        in          : asynchronous active-low reset
//   run        in          : continuous mode while high
//   period     in  DIV_W   : pulse spacing minus one
//   burst_req  in          : burst request (rising edge)
//   burst_len  in  BURST_W : pulses per burst, sampled with the accepted request
//   step_req   in          : single-step request (rising edge)
//   ce_out     out         : enable pulse
//   step_ack   out         : high in the cycle the step pulse is issued
//   burst_done out         : high with the last pulse of a burst (or alone for len 0)
//   busy       out         : state is not IDLE
//   dbg_state  out 2       : current FSM state
// Handshake: requests are edge events only; an edge is accepted only in IDLE
// and dropped otherwise. There is no back-pressure; outputs are decoded from
// registers so no input reaches an output combinationally.
module ce_pulse_gen
  import ce_gen_pkg::*;
#(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DIV_W-1:0]   period,
  input  logic               burst_req,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               step_req,
  output logic               ce_out,
  output logic               step_ack,
  output logic               burst_done,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q,   cnt_d;
  logic [BURST_W-1:0] rem_q,   rem_d;
  logic               zero_done_q, zero_done_d;
  logic               burst_pulse, step_pulse;
  logic               cnt_zero;

  rise_detect u_burst_rd (
    .clk    (clk),
    .rst    (rst),
    .in_sig (burst_req),
    .pulse  (burst_pulse)
  );

  rise_detect u_step_rd (
    .clk    (clk),
    .rst    (rst),
    .in_sig (step_req),
    .pulse  (step_pulse)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    zero_done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
          cnt_d   = period;
        end else if (burst_pulse) begin
          if (burst_len == '0) begin
            // Empty burst completes immediately without any enable pulse.
            zero_done_d = 1'b1;
          end else begin
            state_d = ST_BURST;
            cnt_d   = period;
            rem_d   = burst_len;
          end
        end else if (step_pulse) begin
          state_d = ST_STEP;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          // New period only takes effect at reload.
          cnt_d = period;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_BURST: begin
        if (cnt_zero) begin
          rem_d = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = period;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      ST_STEP: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign ce_out     = (state_q != ST_IDLE) && cnt_zero;
  assign step_ack   = (state_q == ST_STEP);
  assign burst_done = zero_done_q ||
                      ((state_q == ST_BURST) && cnt_zero && (rem_q == BURST_W'(1)));
  assign busy       = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ce_pulse_gen.sv
// tb_ce_pulse_gen
// Directed bench for ce_pulse_gen. Inputs change 1 ns after a rising edge and
// outputs are sampled at that same point. Observed vector is
// {ce_out, step_ack, burst_done, busy}.
module tb_ce_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] period;
  logic       burst_req;
  logic [7:0] burst_len;
  logic       step_req;
  logic       ce_out;
  logic       step_ack;
  logic       burst_done;
  logic       busy;
  logic [1:0] dbg_state;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ce_pulse_gen #(.DIV_W(8), .BURST_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .period     (period),
    .burst_req  (burst_req),
    .burst_len  (burst_len),
    .step_req   (step_req),
    .ce_out     (ce_out),
    .step_ack   (step_ack),
    .burst_done (burst_done),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {ce_out, step_ack, burst_done, busy};
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed ce/ack/done/busy=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick_chk(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    logic [3:0] exp;
    rst       = 1'b0;
    run       = 1'b0;
    period    = 8'd0;
    burst_req = 1'b0;
    burst_len = 8'd0;
    step_req  = 1'b0;

    // Reset state.
    #2;
    chk("reset_hold", 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) tick_chk("idle_after_reset", 4'b0000);

    // Continuous run, period 4; switch to period 1 after cycle 7.
    period = 8'd4;
    run    = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp = (k == 5 || k == 10 || k == 12 || k == 14 || k == 16 || k == 18 || k == 20)
            ? 4'b1001 : 4'b0001;
      chk($sformatf("run_cycle_%0d", k), exp);
      if (k == 7) period = 8'd1;
    end
    run = 1'b0;
    tick_chk("run_exit", 4'b0000);
    tick_chk("run_exit_idle", 4'b0000);

    // Burst of 3, period 2, with a second request edge mid-burst.
    period    = 8'd2;
    burst_len = 8'd3;
    burst_req = 1'b1;
    tick_chk("burst_edge_reg", 4'b0000);
    tick_chk("burst_enter", 4'b0001);
    tick_chk("burst_c2", 4'b0001);
    burst_req = 1'b0;
    tick_chk("burst_p1", 4'b1001);
    tick_chk("burst_c4", 4'b0001);
    burst_req = 1'b1;
    tick_chk("burst_c5", 4'b0001);
    tick_chk("burst_p2", 4'b1001);
    tick_chk("burst_c7", 4'b0001);
    tick_chk("burst_c8", 4'b0001);
    tick_chk("burst_p3_done", 4'b1011);
    tick_chk("burst_busy_drop", 4'b0000);
    tick_chk("burst_no_extra", 4'b0000);
    burst_req = 1'b0;
    tick_chk("burst_idle", 4'b0000);

    // Single step held high, then a second step.
    step_req = 1'b1;
    tick_chk("step_edge_reg", 4'b0000);
    tick_chk("step_pulse", 4'b1101);
    for (int i = 0; i < 8; i++) tick_chk("step_held", 4'b0000);
    step_req = 1'b0;
    tick_chk("step_low", 4'b0000);
    step_req = 1'b1;
    tick_chk("step2_edge_reg", 4'b0000);
    tick_chk("step2_pulse", 4'b1101);
    tick_chk("step2_after", 4'b0000);
    step_req = 1'b0;

    // Zero-length burst.
    burst_len = 8'd0;
    burst_req = 1'b1;
    tick_chk("zlen_edge_reg", 4'b0000);
    tick_chk("zlen_done", 4'b0010);
    tick_chk("zlen_after", 4'b0000);
    burst_req = 1'b0;
    tick_chk("zlen_idle", 4'b0000);

    // Reset in the middle of a burst with two pulses remaining.
    burst_len = 8'd3;
    burst_req = 1'b1;
    tick_chk("rb_edge_reg", 4'b0000);
    tick_chk("rb_enter", 4'b0001);
    tick_chk("rb_c2", 4'b0001);
    tick_chk("rb_p1", 4'b1001);
    tick_chk("rb_rem2", 4'b0001);
    #2;
    rst = 1'b0;
    #1;
    chk("rb_async_clear", 4'b0000);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) tick_chk("rb_after_release", 4'b0000);

    // A fresh request after reset is still accepted.
    burst_req = 1'b0;
    tick_chk("rb_req_low", 4'b0000);
    burst_req = 1'b1;
    tick_chk("rb_new_edge_reg", 4'b0000);
    tick_chk("rb_new_burst", 4'b0001);
    burst_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
